// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a RESET/FETCH/ISSUE FSM that requests one word per PC, holds it in an IR
// and presents decoder fields. A fetch that waits too long drops its request for one cycle and retries.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [1:0]  Op,
  output logic [5:0]  Funct,
  output logic [31:0] pc_plus8,
  output logic        fetch_timeout
);

  typedef enum logic [1:0] {StReset, StFetch, StIssue} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] issue_pc_q, issue_pc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        gap_q, gap_d;
  logic        timeout_q, timeout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StReset;
      pc_q       <= RESET_PC;
      ir_q       <= 32'h0;
      issue_pc_q <= RESET_PC;
      cnt_q      <= 8'h0;
      gap_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      issue_pc_q <= issue_pc_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    issue_pc_d  = issue_pc_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    timeout_d   = timeout_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      StReset: begin
        state_d = StFetch;
        cnt_d   = 8'h0;
        gap_d   = 1'b0;
      end
      StFetch: begin
        // gap_q marks the single idle cycle between a timed-out request and its retry
        if (gap_q) begin
          gap_d = 1'b0;
        end else begin
          imem_req = 1'b1;
          if (imem_valid) begin
            ir_d       = imem_rdata;
            issue_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            cnt_d      = 8'h0;
            state_d    = StIssue;
          end else if (cnt_q == CntLast) begin
            timeout_d = 1'b1;
            cnt_d     = 8'h0;
            gap_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StIssue: begin
        instr_valid = 1'b1;
        if (!stall) begin
          state_d = StFetch;
          cnt_d   = 8'h0;
          gap_d   = 1'b0;
          if (pc_src) pc_d = {branch_target[31:2], 2'b00};
        end
      end
      default: state_d = StReset;
    endcase
  end

  assign imem_addr     = pc_q;
  assign instr         = ir_q;
  assign Op            = ir_q[27:26];
  assign Funct         = ir_q[25:20];
  assign pc_plus8      = issue_pc_q + 32'd8;
  assign fetch_timeout = timeout_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected request addresses and issued words are queued
// as stimulus is driven and compared by a negedge monitor when the DUT produces them.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [31:0] pc_plus8;
  logic        fetch_timeout;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .stall        (stall),
    .pc_src       (pc_src),
    .branch_target(branch_target),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .Op           (Op),
    .Funct        (Funct),
    .pc_plus8     (pc_plus8),
    .fetch_timeout(fetch_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc8;
  } issue_t;

  logic [31:0] exp_addr_q[$];
  issue_t      exp_issue_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Monitor: compare on the first cycle of each request and of each issue
  logic prev_req = 1'b0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (imem_req && !prev_req) begin
      if (exp_addr_q.size() == 0) check_eq("addr_unexpected", imem_addr, 32'hFFFF_FFFF);
      else check_eq("req_addr", imem_addr, exp_addr_q.pop_front());
    end
    if (instr_valid && !prev_valid) begin
      if (exp_issue_q.size() == 0) begin
        check_eq("issue_unexpected", instr, 32'hFFFF_FFFF);
      end else begin
        issue_t e;
        e = exp_issue_q.pop_front();
        check_eq("instr", instr, e.word);
        check_eq("op", {30'h0, Op}, {30'h0, e.word[27:26]});
        check_eq("funct", {26'h0, Funct}, {26'h0, e.word[25:20]});
        check_eq("pc_plus8", pc_plus8, e.pc8);
      end
    end
    prev_req   = imem_req;
    prev_valid = instr_valid;
  end

  task automatic wait_req();
    int n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (imem_req) break;
      n++;
    end
    if (n == 100) check_eq("req_wait_timeout", 32'h0, 32'h1);
  endtask

  // Answer the pending request after lat idle cycles; leaves DUT in ISSUE at posedge+1
  task automatic serve(input logic [31:0] data, input int lat);
    issue_t e;
    wait_req();
    repeat (lat) @(negedge clk);
    imem_valid = 1'b1;
    imem_rdata = data;
    e.word = data;
    e.pc8  = model_pc + 32'd8;
    exp_issue_q.push_back(e);
    @(posedge clk);
    #1;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    model_pc   = model_pc + 32'd4;
  endtask

  // Hold ISSUE for n stalled cycles (pc_src=stall_src there), then release with pc_src=br
  task automatic consume(input int n, input logic stall_src, input logic br,
                         input logic [31:0] tgt);
    for (int i = 0; i < n; i++) begin
      stall = 1'b1;
      pc_src = stall_src;
      branch_target = 32'h0000_0203;
      @(negedge clk);
      check_eq("stall_valid", {31'h0, instr_valid}, 32'h1);
      check_eq("stall_noreq", {31'h0, imem_req}, 32'h0);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    pc_src = br;
    branch_target = tgt;
    @(negedge clk);
    check_eq("issue_valid", {31'h0, instr_valid}, 32'h1);
    check_eq("issue_noreq", {31'h0, imem_req}, 32'h0);
    @(posedge clk);
    #1;
    pc_src = 1'b0;
    if (br) model_pc = {tgt[31:2], 2'b00};
    exp_addr_q.push_back(model_pc);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_req", {31'h0, imem_req}, 32'h0);
    check_eq("rst_valid", {31'h0, instr_valid}, 32'h0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_op", {30'h0, Op}, 32'h0);
    check_eq("rst_funct", {26'h0, Funct}, 32'h0);
    check_eq("rst_pc_plus8", pc_plus8, RESET_PC + 32'd8);
    check_eq("rst_timeout", {31'h0, fetch_timeout}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    imem_rdata = 32'h0;
    imem_valid = 1'b0;
    stall = 1'b0;
    pc_src = 1'b0;
    branch_target = 32'h0;
    model_pc = RESET_PC;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    exp_addr_q.push_back(RESET_PC);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic fetch, same-cycle response
    serve(32'hE082_0001, 0);
    check_eq("basic_op", {30'h0, Op}, 32'h0);
    check_eq("basic_funct", {26'h0, Funct}, 32'h08);
    consume(0, 1'b0, 1'b0, 32'h0);

    // load-type word, delayed response, three stall cycles
    serve(32'hE591_0000, 2);
    check_eq("ldr_op", {30'h0, Op}, 32'h1);
    check_eq("ldr_ibit", {31'h0, Funct[5]}, 32'h0);
    check_eq("ldr_lbit", {31'h0, Funct[0]}, 32'h1);
    consume(3, 1'b0, 1'b0, 32'h0);

    // reset asserted mid-wait at addr 8
    wait_req();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    model_pc = RESET_PC;
    exp_addr_q.push_back(RESET_PC);
    rst = 1'b0;

    // branch word; pc_src during stall must be ignored
    serve(32'hEA00_0002, 1);
    check_eq("b_op", {30'h0, Op}, 32'h2);
    consume(1, 1'b1, 1'b0, 32'h0);
    serve(32'hE082_0001, 0);
    consume(0, 1'b0, 1'b1, 32'h0000_0103);

    // timeout at 0x100: 16 unanswered cycles, one idle cycle, retry same address
    wait_req();
    repeat (15) @(negedge clk);
    check_eq("wait_req_held", {31'h0, imem_req}, 32'h1);
    check_eq("wait_addr_held", imem_addr, model_pc);
    check_eq("pre_timeout_flag", {31'h0, fetch_timeout}, 32'h0);
    exp_addr_q.push_back(model_pc);
    @(negedge clk);
    check_eq("timeout_gap_req", {31'h0, imem_req}, 32'h0);
    check_eq("timeout_flag", {31'h0, fetch_timeout}, 32'h1);
    serve(32'hE591_0000, 0);
    check_eq("timeout_sticky", {31'h0, fetch_timeout}, 32'h1);
    consume(0, 1'b0, 1'b0, 32'h0);
    serve(32'hEA00_0002, 0);
    consume(0, 1'b0, 1'b0, 32'h0);
    wait_req();
    repeat (3) @(negedge clk);

    check_eq("issue_queue_empty", exp_issue_q.size(), 32'h0);
    check_eq("addr_queue_empty", exp_addr_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter: TIMEOUT, 16, cycles waited for imem_valid before a fetch is retried (range 2..255).
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port: imem_addr  output  32  byte address of the requested word (current PC).
REQ-007 SHALL have port: imem_rdata  input  32  instruction word from memory, sampled only when imem_valid=1.
REQ-008 SHALL have port: imem_valid  input  1  memory response strobe; may assert in the same cycle as imem_req.
REQ-009 SHALL have port: stall  input  1  decoder/datapath not ready to consume the issued instruction.
REQ-010 SHALL have port: pc_src  input  1  taken branch/PC write; sampled only in ISSUE.
REQ-011 SHALL have port: branch_target  input  32  next PC when pc_src=1.
REQ-012 SHALL have port: instr_valid  output  1  instr and decoded fields are valid this cycle.
REQ-013 SHALL have port: instr  output  32  held instruction register (IR).
REQ-014 SHALL have port: Op  output  2  IR[27:26], driven to the main decoder Op input.
REQ-015 SHALL have port: Funct  output  6  IR[25:20]; Funct[5] = I bit, Funct[0] = S/L bit for the main decoder.
REQ-016 SHALL have port: pc_plus8  output  32  address of the issued instruction + 8 (ARM PC read value).
REQ-017 SHALL have port: fetch_timeout  output  1  sticky flag: at least one fetch timed out since reset.

Function
REQ-018 SHALL implement FSM with states RESET, FETCH, ISSUE.
REQ-019 SHALL, in RESET, drive imem_req=0 and instr_valid=0, and go to FETCH on the first clock edge after rst deasserts.
REQ-020 SHALL, in FETCH, drive imem_req=1 and imem_addr=PC, holding both stable until imem_valid=1.
REQ-021 SHALL, in FETCH with imem_valid=1: load IR<=imem_rdata, load issue_pc<=PC, load PC<=PC+4 (mod 2^32), and go to ISSUE; minimum FETCH-to-ISSUE latency is 1 cycle.
REQ-022 SHALL count FETCH cycles without imem_valid; when the count reaches TIMEOUT, set fetch_timeout=1, clear the counter, deassert imem_req for exactly one cycle, then re-request the same PC.
REQ-023 SHALL clear the timeout counter on every entry to FETCH.
REQ-024 SHALL, in ISSUE, drive instr_valid=1 and imem_req=0, with Op/Funct/instr taken from the IR and pc_plus8=issue_pc+8.
REQ-025 SHALL, in ISSUE with stall=1, remain in ISSUE, hold the IR and PC, and ignore pc_src.
REQ-026 SHALL, in ISSUE with stall=0, go to FETCH; if pc_src=1, PC<=branch_target, overriding the PC+4 value.
REQ-027 SHALL force branch_target[1:0] to 2'b00 when loading it into PC.
REQ-028 SHALL ignore imem_valid outside FETCH, with no state change.
REQ-029 SHALL drive Op, Funct and instr from the IR in all states; they are meaningful only while instr_valid=1.

Reset
REQ-030 SHALL, while rst=1 (asynchronous): PC=RESET_PC, IR=0, issue_pc=RESET_PC, state=RESET, counter=0, fetch_timeout=0.
REQ-031 SHALL, while rst=1, drive imem_req=0, instr_valid=0, Op=0, Funct=0, instr=0 and pc_plus8=RESET_PC+8.
REQ-032 SHALL abort any in-flight fetch or issue when rst asserts mid-operation; the first request after release is at RESET_PC.

Verification
REQ-033 SHALL cover basic fetch: release reset, memory answers in the same cycle with 32'hE082_0001 -> imem_addr=0; next cycle instr_valid=1, Op=2'b00, Funct=6'b001000, pc_plus8=8; the following request is at addr 4.
REQ-034 SHALL cover decoder fields: IR=32'hE591_0000 -> Op=2'b01, Funct[5]=0, Funct[0]=1; IR=32'hEA00_0002 -> Op=2'b10.
REQ-035 SHALL cover stall: stall=1 for 3 ISSUE cycles -> instr_valid held for 4 cycles with no imem_req; then next fetch at PC+4.
REQ-036 SHALL cover branch: pc_src=1 with branch_target=32'h0000_0103 in ISSUE with stall=0 -> next imem_addr=32'h0000_0100; pc_src=1 with stall=1 -> ignored.
REQ-037 SHALL cover timeout: imem_valid held low for 16 FETCH cycles -> fetch_timeout=1, imem_req=0 for one cycle, then re-request at the same address; a later response completes normally with fetch_timeout still 1.
REQ-038 SHALL cover reset mid-wait: rst pulsed asynchronously during FETCH at addr 8 -> outputs go to reset values immediately; the first request after release is at RESET_PC.
